// File: rtl/mmm_pkg.sv
// Shared constants for the mod (2^DW-1) accumulator: default width, FSM encoding, negative zero.
package mmm_pkg;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FOLD  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  localparam logic [DW_DEF-1:0] NEG_ZERO = '1;
endpackage

// File: rtl/mod_accum_add.sv
// Combinational W-bit adder with carry-in and carry-out; shared by the accumulate and fold steps.
module mod_accum_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mod_accum_mmm.sv
// Streaming mod (2^DW-1) accumulator with end-around-carry fold.
// Optional CANON_ZERO_EN: report negative zero (all-ones) as 0.
module mod_accum_mmm
  import mmm_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            aclr,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_sub,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_result,
  output logic [CNTW-1:0] m_words
);
  state_t          state, state_nxt;
  logic [DW-1:0]   acc, op, add_b, sum, res_cap;
  logic            carry, cout, folded, fire, fold_done;
  logic [CNTW-1:0] count;

  assign op        = s_sub ? ~s_data : s_data;
  assign add_b     = (state == ST_ACCUM) ? op : '0;
  // A fold pass always runs before the registered carry is trusted as final.
  assign fold_done = folded && !carry;

`ifdef CANON_ZERO_EN
  assign res_cap = (acc == {DW{1'b1}}) ? '0 : acc;
`else
  assign res_cap = acc;
`endif

  mod_accum_add #(.W(DW)) u_add (
    .a    (acc),
    .b    (add_b),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_ACCUM: begin
        s_ready = 1'b1;
        fire    = s_valid;
        if (s_valid && s_last) state_nxt = ST_FOLD;
      end
      ST_FOLD: if (fold_done) state_nxt = ST_OUT;
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = ST_ACCUM;
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state    <= ST_ACCUM;
      acc      <= '0;
      carry    <= 1'b0;
      folded   <= 1'b0;
      count    <= '0;
      m_result <= '0;
      m_words  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_ACCUM: begin
          folded <= 1'b0;
          if (fire) begin
            acc   <= sum;
            carry <= cout;
            count <= (count == {CNTW{1'b1}}) ? count : count + 1'b1;
          end
        end
        ST_FOLD: begin
          acc    <= sum;
          carry  <= cout;
          folded <= 1'b1;
          if (fold_done) begin
            m_result <= res_cap;
            m_words  <= count;
          end
        end
        ST_OUT: if (m_ready) begin
          acc   <= '0;
          carry <= 1'b0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_accum_mmm.sv
// Self-checking bench for mod_accum_mmm: directed frames plus randomized frames vs a modular-arithmetic model.
module tb_mod_accum_mmm;
  localparam int DW   = 32;
  localparam int CNTW = 4;
  localparam longint unsigned M = 64'hFFFF_FFFF;

  logic            clock = 1'b0;
  logic            aclr  = 1'b1;
  logic            s_valid = 1'b0, s_ready, s_sub = 1'b0, s_last = 1'b0;
  logic [DW-1:0]   s_data = '0;
  logic            m_valid, m_ready = 1'b1;
  logic [DW-1:0]   m_result;
  logic [CNTW-1:0] m_words;

  int tests = 0, fails = 0;
  logic [31:0] fd [32];
  logic        fs [32];

  always #5 clock = ~clock;

  mod_accum_mmm #(.DW(DW), .CNTW(CNTW)) dut (
    .clock(clock), .aclr(aclr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sub(s_sub), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_words(m_words)
  );

  // Ones-complement sum of the frame, computed as a residue mod 2^32-1.
  // Only a frame of all-zero operands yields positive zero.
  function automatic logic [31:0] model(input int n);
    longint unsigned r = 0, v;
    bit nonzero = 0;
    logic [31:0] opv;
    for (int i = 0; i < n; i++) begin
      v = longint'(fd[i]) % M;
      opv = fs[i] ? ~fd[i] : fd[i];
      if (opv != 0) nonzero = 1;
      r = fs[i] ? (r + M - v) % M : (r + v) % M;
    end
    if (r != 0) return r[31:0];
`ifdef CANON_ZERO_EN
    return 32'h0;
`else
    return nonzero ? 32'hFFFF_FFFF : 32'h0;
`endif
  endfunction

  task automatic send(input logic [31:0] d, input logic sb, input logic lst, input bit gap);
    int w = 0;
    if (gap && $urandom_range(0, 2) == 0) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
    end
    s_valid = 1'b1; s_data = d; s_sub = sb; s_last = lst;
    while (!s_ready && w < 20) begin @(posedge clock); #1; w++; end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clock); #1;
    if (lst) begin s_valid = 1'b0; s_last = 1'b0; end
  endtask

  task automatic run_frame(input string nm, input int n, input bit gap, input int hold);
    logic [31:0]     er, r0;
    logic [CNTW-1:0] ew;
    int lat = 0;
    er = model(n);
    ew = (n > 15) ? 4'hF : CNTW'(n);
    for (int i = 0; i < n; i++) send(fd[i], fs[i], (i == n - 1), gap);
    m_ready = 1'b0;
    while (!m_valid && lat < 20) begin @(posedge clock); #1; lat++; end
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL %s latency: got %0d edges required 2", nm, lat); end
    tests++;
    if (m_result !== er) begin fails++; $display("FAIL %s result: got %h required %h", nm, m_result, er); end
    tests++;
    if (m_words !== ew) begin fails++; $display("FAIL %s words: got %0d required %0d", nm, m_words, ew); end
    r0 = m_result;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      tests++;
      if (m_valid !== 1'b1 || m_result !== r0 || s_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold%0d: m_valid=%b m_result=%h s_ready=%b required 1 %h 0", nm, k, m_valid, m_result, s_ready, r0);
      end
    end
    m_ready = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      fails++; $display("FAIL %s release: m_valid=%b s_ready=%b required 0 1", nm, m_valid, s_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (m_valid !== 0 || s_ready !== 1 || m_result !== 0 || m_words !== 0) begin
      fails++;
      $display("FAIL reset: m_valid=%b s_ready=%b m_result=%h m_words=%0d required 0 1 0 0", m_valid, s_ready, m_result, m_words);
    end
    @(posedge clock); #1;
    aclr = 1'b0;
  endtask

  task automatic test_directed();
    fd[0] = 32'h5; fs[0] = 0;
    run_frame("single", 1, 0, 0);
    fd[0] = 32'hFFFF_FFFE; fs[0] = 0; fd[1] = 32'h3; fs[1] = 0;
    run_frame("carry_fold", 2, 0, 0);
    fd[0] = 32'h10; fs[0] = 0; fd[1] = 32'h3; fs[1] = 1;
    run_frame("add_sub", 2, 0, 0);
    fd[0] = 32'h5; fs[0] = 0; fd[1] = 32'h5; fs[1] = 1;
    run_frame("neg_zero", 2, 0, 0);
    fd[0] = 32'hFFFF_FFFF; fs[0] = 0; fd[1] = 32'hFFFF_FFFF; fs[1] = 0; fd[2] = 32'h1; fs[2] = 0;
    run_frame("all_ones_bp", 3, 0, 5);
    fd[0] = 32'h0; fs[0] = 0; fd[1] = 32'h0; fs[1] = 0;
    run_frame("pos_zero", 2, 0, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin fd[i] = $urandom; fs[i] = 1'($urandom_range(0, 1)); end
    run_frame("saturate", 20, 0, 0);
  endtask

  task automatic test_abort();
    send(32'h1234_5678, 0, 0, 0);
    send(32'h0000_0042, 0, 0, 0);
    s_valid = 1'b0;
    #2 aclr = 1'b1;
    #2;
    tests++;
    if (m_valid !== 0 || s_ready !== 1 || m_result !== 0 || m_words !== 0) begin
      fails++;
      $display("FAIL abort_reset: m_valid=%b s_ready=%b m_result=%h m_words=%0d required 0 1 0 0", m_valid, s_ready, m_result, m_words);
    end
    @(posedge clock); #1;
    aclr = 1'b0;
    fd[0] = 32'h7; fs[0] = 0;
    run_frame("after_abort", 1, 0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 25; f++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        fd[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
        fs[i] = 1'($urandom_range(0, 1));
      end
      run_frame("random", n, 1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_saturation();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
